// File: rtl/hap_cmp_pkg.sv
// Shared opcode encodings, scheduler state type and opcode legality check
// for the compare scheduler.
package hap_cmp_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_LT  = 5'b01011;
    localparam logic [OP_W-1:0] OP_GT  = 5'b01100;
    localparam logic [OP_W-1:0] OP_EQ  = 5'b01101;
    localparam logic [OP_W-1:0] OP_GTE = 5'b01110;
    localparam logic [OP_W-1:0] OP_LTE = 5'b01111;
    localparam logic [OP_W-1:0] OP_NE  = 5'b10000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } cmp_state_t;

    function automatic logic is_cmp_op(input logic [OP_W-1:0] op);
        return (op == OP_LT)  || (op == OP_GT)  || (op == OP_EQ) ||
               (op == OP_GTE) || (op == OP_LTE) || (op == OP_NE);
    endfunction

endpackage

// File: rtl/cmp_rr_pick.sv
// One-hot winner select: first valid requester found when searching upward
// from ptr with wrap-around. A constant-zero ptr gives fixed priority.
module cmp_rr_pick
    import hap_cmp_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_scheduler.sv
// Shares one combinational compare unit between NREQ requesters.
// Build option CMP_SCHED_RR_EN: round-robin arbitration (fixed priority otherwise).
//
//   state | meaning
//   IDLE  | waiting for a request; grant one and register its operands
//   EXEC  | compare unit settles; capture its result
//   RESP  | hold the response until the granted requester takes it
module cmp_scheduler
    import hap_cmp_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = 3,
    parameter int OPW  = 5
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_opcode,
    input  logic [NREQ*DW-1:0]  req_a,
    input  logic [NREQ*DW-1:0]  req_b,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [DW-1:0]       rsp_data,
    output logic                rsp_err,
    output logic [OPW-1:0]      cmp_opcode,
    output logic [DW-1:0]       cmp_r1,
    output logic [DW-1:0]       cmp_r2,
    input  logic [DW-1:0]       cmp_rd
);

    localparam int PW = $clog2(NREQ);

    cmp_state_t      state_q, state_d;
    logic [NREQ-1:0] pick_gnt;
    logic [NREQ-1:0] gnt_q;
    logic [PW-1:0]   ptr;
    logic [OPW-1:0]  sel_op;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;
    logic            take_req;
    logic            rsp_done;

    cmp_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick_gnt)
    );

    assign take_req = (state_q == IDLE) && (|req_valid);
    assign rsp_done = (state_q == RESP) && (|(rsp_ready & gnt_q));

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_op = req_opcode[i*OPW +: OPW];
                sel_a  = req_a[i*DW +: DW];
                sel_b  = req_b[i*DW +: DW];
            end
        end
    end

    // req_ready is combinational, so it is also masked while reset is held.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (take_req) begin
                    req_ready = Rst_n ? pick_gnt : '0;
                    state_d   = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            gnt_q      <= '0;
            cmp_opcode <= '0;
            cmp_r1     <= '0;
            cmp_r2     <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_req) begin
                        gnt_q      <= pick_gnt;
                        cmp_opcode <= sel_op;
                        cmp_r1     <= sel_a;
                        cmp_r2     <= sel_b;
                    end
                end
                EXEC: begin
                    rsp_valid <= gnt_q;
                    if (is_cmp_op(OP_W'(cmp_opcode))) begin
                        rsp_data <= cmp_rd;
                        rsp_err  <= 1'b0;
                    end else begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_done) rsp_valid <= '0;
                end
                default: rsp_valid <= '0;
            endcase
        end
    end

`ifdef CMP_SCHED_RR_EN
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_nxt;

    // Next search starts just past the requester that was served.
    always_comb begin
        ptr_nxt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr_q <= '0;
        end else if (rsp_done) begin
            ptr_q <= ptr_nxt;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

endmodule

// File: tb/tb_cmp_scheduler.sv
// Randomized and directed bench for cmp_scheduler against a transaction-level
// model of arbitration, latency and compare results.
module tb_cmp_scheduler;

    localparam int NREQ = 2;
    localparam int DW   = 3;
    localparam int OPW  = 5;

    logic                Clk = 1'b0;
    logic                Rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_opcode = '0;
    logic [NREQ*DW-1:0]  req_a = '0;
    logic [NREQ*DW-1:0]  req_b = '0;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready = '0;
    logic [DW-1:0]       rsp_data;
    logic                rsp_err;
    logic [OPW-1:0]      cmp_opcode;
    logic [DW-1:0]       cmp_r1;
    logic [DW-1:0]       cmp_r2;
    logic [DW-1:0]       cmp_rd;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    cmp_scheduler #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .cmp_opcode (cmp_opcode),
        .cmp_r1     (cmp_r1),
        .cmp_r2     (cmp_r2),
        .cmp_rd     (cmp_rd)
    );

    // Comparison result by opcode value; -1 marks an illegal opcode.
    function automatic int ref_cmp(input int op, input int a, input int b);
        case (op)
            11: return int'(a <  b);
            12: return int'(a >  b);
            13: return int'(a == b);
            14: return int'(a >= b);
            15: return int'(a <= b);
            16: return int'(a != b);
            default: return -1;
        endcase
    endfunction

    // Stand-in for the external compare unit; drives junk on illegal opcodes.
    function automatic logic [DW-1:0] cmp_unit(input logic [OPW-1:0] op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        int r;
        r = ref_cmp(int'(op), int'(a), int'(b));
        return (r < 0) ? DW'(5) : DW'(r);
    endfunction

    assign cmp_rd = cmp_unit(cmp_opcode, cmp_r1, cmp_r2);

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            int k = (ptr + i) % NREQ;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Transaction model: one op in flight, age counts edges since acceptance.
    bit             m_busy = 1'b0;
    int             m_g = 0;
    int             m_age = 0;
    int             m_ptr = 0;
    logic [OPW-1:0] m_op = '0;
    logic [DW-1:0]  m_a = '0;
    logic [DW-1:0]  m_b = '0;
    int             grant_log[$];

    int              c_g;
    int              c_r;
    logic [NREQ-1:0] c_rr;
    logic [NREQ-1:0] c_rv;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_rsp_err", rsp_err, 0);
            check("rst_cmp_opcode", cmp_opcode, 0);
            check("rst_cmp_r1", cmp_r1, 0);
            check("rst_cmp_r2", cmp_r2, 0);
        end else begin
            c_g  = pick(req_valid, m_ptr);
            c_rr = (!m_busy && c_g >= 0) ? NREQ'(1 << c_g) : '0;
            check("req_ready", req_ready, c_rr);
            c_rv = (m_busy && m_age >= 2) ? NREQ'(1 << m_g) : '0;
            check("rsp_valid", rsp_valid, c_rv);
            if (c_rv != 0) begin
                c_r = ref_cmp(int'(m_op), int'(m_a), int'(m_b));
                check("rsp_data", rsp_data, (c_r < 0) ? 0 : c_r);
                check("rsp_err", rsp_err, (c_r < 0) ? 1 : 0);
            end
            if (m_busy) begin
                check("cmp_opcode", cmp_opcode, m_op);
                check("cmp_r1", cmp_r1, m_a);
                check("cmp_r2", cmp_r2, m_b);
            end
            if (!m_busy) begin
                if (c_g >= 0) begin
                    m_busy = 1'b1;
                    m_g    = c_g;
                    m_age  = 1;
                    m_op   = req_opcode[c_g*OPW +: OPW];
                    m_a    = req_a[c_g*DW +: DW];
                    m_b    = req_b[c_g*DW +: DW];
                    grant_log.push_back(c_g);
                end
            end else if (m_age >= 2 && rsp_ready[m_g]) begin
                m_busy = 1'b0;
`ifdef CMP_SCHED_RR_EN
                m_ptr = (m_g + 1) % NREQ;
`endif
            end else begin
                m_age++;
            end
        end
    end

    // Which requesters were accepted at the last edge (for the random driver).
    logic [NREQ-1:0] acc;
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) acc <= '0;
        else        acc <= req_ready & req_valid;
    end

    task automatic set_req(input int i, input logic [OPW-1:0] op,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_valid[i]             = 1'b1;
        req_opcode[i*OPW +: OPW] = op;
        req_a[i*DW +: DW]        = a;
        req_b[i*DW +: DW]        = b;
    endtask

    task automatic apply_reset();
        @(posedge Clk); #1;
        Rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
    endtask

    // Wait for requester i to be granted, drop its valid, then check the response.
    task automatic serve(input int i, input string tag, input int exp_data, input int exp_err);
        int n;
        int lat;
        n = 0;
        @(negedge Clk);
        while (!req_ready[i] && n < 40) begin
            @(negedge Clk);
            n++;
        end
        if (!req_ready[i]) begin
            checks++;
            errors++;
            $display("FAIL %s_grant: req_ready[%0d] got 0 expected 1 within 40 cycles", tag, i);
            return;
        end
        @(posedge Clk); #1;
        req_valid[i] = 1'b0;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!rsp_valid[i] && lat < 20);
        check({tag, "_latency"}, lat, 2);
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_err"}, rsp_err, exp_err);
    endtask

    function automatic logic [OPW-1:0] rand_op();
        if ($urandom_range(0, 4) == 0) return OPW'($urandom_range(0, 31));
        return OPW'(11 + $urandom_range(0, 5));
    endfunction

    int n0;
    int k;
    int exp_seq[4];

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_cmp_opcode", cmp_opcode, 0);
        Rst_n = 1'b1;

        // LT 3,5 from requester 0
        set_req(0, 5'b01011, 3'd3, 3'd5);
        rsp_ready = '1;
        serve(0, "lt", 1, 0);

        // simultaneous requests: req0 first after reset
        apply_reset();
        rsp_ready = '1;
        n0 = grant_log.size();
        set_req(0, 5'b01100, 3'd7, 3'd3);
        set_req(1, 5'b01101, 3'd1, 3'd6);
        serve(0, "gt", 1, 0);
        serve(1, "eq", 0, 0);
        if (grant_log.size() >= n0 + 2) begin
            check("order_first", grant_log[n0], 0);
            check("order_second", grant_log[n0 + 1], 1);
        end else begin
            checks++;
            errors++;
            $display("FAIL order: got %0d grants expected 2", grant_log.size() - n0);
        end

        // continuous requests from both
        apply_reset();
        rsp_ready = '1;
        n0 = grant_log.size();
        set_req(0, 5'b01100, 3'd7, 3'd3);
        set_req(1, 5'b01101, 3'd1, 3'd6);
        k = 0;
        while (grant_log.size() < n0 + 4 && k < 60) begin
            @(negedge Clk);
            k++;
        end
`ifdef CMP_SCHED_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        if (grant_log.size() >= n0 + 4) begin
            for (int j = 0; j < 4; j++) check($sformatf("grant_seq%0d", j), grant_log[n0 + j], exp_seq[j]);
        end else begin
            checks++;
            errors++;
            $display("FAIL grant_seq: got %0d grants expected 4", grant_log.size() - n0);
        end

        // illegal opcode, then a normal op to show recovery
        apply_reset();
        rsp_ready = '1;
        set_req(1, 5'b00101, 3'd3, 3'd4);
        serve(1, "illegal", 0, 1);
        set_req(1, 5'b01011, 3'd0, 3'd7);
        serve(1, "after_illegal", 1, 0);

        // response stall with a pending request behind it
        apply_reset();
        set_req(0, 5'b01110, 3'd4, 3'd4);
        serve(0, "stall", 1, 0);
        @(posedge Clk); #1;
        set_req(0, 5'b01011, 3'd1, 3'd2);
        repeat (5) begin
            @(negedge Clk);
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_req_ready", req_ready, 0);
            check("stall_data", rsp_data, 1);
            check("stall_cmp_opcode", cmp_opcode, 5'b01110);
        end
        @(posedge Clk); #1;
        rsp_ready[0] = 1'b1;
        serve(0, "stall_next", 1, 0);

        // reset during EXEC
        apply_reset();
        rsp_ready = '1;
        set_req(0, 5'b01101, 3'd5, 3'd5);
        @(negedge Clk);
        check("rst_exec_grant", req_ready, 1);
        @(posedge Clk); #1;
        Rst_n = 1'b0;
        #1;
        check("rst_exec_req_ready", req_ready, 0);
        check("rst_exec_rsp_valid", rsp_valid, 0);
        check("rst_exec_rsp_data", rsp_data, 0);
        check("rst_exec_rsp_err", rsp_err, 0);
        check("rst_exec_cmp_opcode", cmp_opcode, 0);
        check("rst_exec_cmp_r1", cmp_r1, 0);
        check("rst_exec_cmp_r2", cmp_r2, 0);
        req_valid = '0;
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        set_req(0, 5'b10000, 3'd2, 3'd2);
        serve(0, "ne_after_rst", 0, 0);

        // randomized traffic
        apply_reset();
        repeat (800) begin
            @(posedge Clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, rand_op(), DW'($urandom), DW'($urandom));
            end
            rsp_ready = NREQ'($urandom);
        end

        @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
